// File: rtl/conv_layer_seq.sv
// Job sequencer for one 9x9 single-channel conv engine: feeds the input map from BRAM,
// gates eng_start, stores engine outputs to BRAM, watchdogs the engine. Option: CONV_SEQ_RELU_EN.
module conv_layer_seq #(
    parameter int IN_PIX    = 9216,
    parameter int OUT_PIX   = 7744,
    parameter int START_OFS = 863,
    parameter int IN_AW     = 14,
    parameter int OUT_AW    = 13,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr,
    input  logic [15:0]       rd_data,
    output logic              eng_clr,
    output logic [15:0]       eng_map_in,
    output logic              eng_start,
    input  logic              eng_save,
    input  logic [15:0]       eng_map_out,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [2:0]        dbg_state
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [IN_AW-1:0]  L_FEED_LAST = IN_AW'(IN_PIX - 1);
    localparam logic [IN_AW-1:0]  L_START     = IN_AW'(START_OFS);
    localparam logic [OUT_AW-1:0] L_OUT_FULL  = OUT_AW'(OUT_PIX);
    localparam logic [WDW-1:0]    L_WD_LAST   = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IN_AW-1:0]   r_pix;
    logic [OUT_AW-1:0]  r_wcnt;
    logic [WDW-1:0]     r_wdog;
    logic               r_start;
    logic               r_err;
    logic               r_rd_vld;
    logic               r_go_blk;
    logic               r_wr_en;
    logic [OUT_AW-1:0]  r_wr_addr;
    logic [15:0]        r_wr_data;

    logic               w_accept;
    logic               w_active;
    logic               w_wr_full;
    logic               w_save_ok;
    logic               w_wd_cnt;
    logic               w_wd_exp;
    logic [15:0]        w_wr_val;

    // A go still high when a job finishes must drop before it can start another job.
    assign w_accept  = (r_state == S_IDLE) && go && !r_go_blk;
    assign w_active  = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_wr_full = (r_wcnt == L_OUT_FULL);
    assign w_save_ok = w_active && eng_save && !w_wr_full;
    assign w_wd_cnt  = ((r_state == S_FEED) && r_start) || (r_state == S_DRAIN);
    assign w_wd_exp  = w_wd_cnt && !eng_save && (r_wdog == L_WD_LAST) && !w_wr_full;

`ifdef CONV_SEQ_RELU_EN
    assign w_wr_val = eng_map_out[15] ? 16'h0000 : eng_map_out;
`else
    assign w_wr_val = eng_map_out;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CLR;
            S_CLR:   w_next = S_FEED;
            S_FEED: begin
                if (w_wd_exp)                  w_next = S_FAULT;
                else if (r_pix == L_FEED_LAST) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_wr_full)     w_next = S_FIN;
                else if (w_wd_exp) w_next = S_FAULT;
            end
            S_FIN:   w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pix     <= '0;
            r_wcnt    <= '0;
            r_wdog    <= '0;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_go_blk  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state  <= w_next;
            r_rd_vld <= (r_state == S_FEED);
            r_wr_en  <= w_save_ok;
            if (w_save_ok) begin
                r_wr_addr <= r_wcnt;
                r_wr_data <= w_wr_val;
                r_wcnt    <= r_wcnt + 1'b1;
            end
            if (w_active && eng_save) r_wdog <= '0;
            else if (w_wd_cnt)        r_wdog <= r_wdog + 1'b1;
            // Pixel START_OFS reaches eng_map_in one cycle after its address issues.
            if (r_state == S_FEED) begin
                r_pix <= r_pix + 1'b1;
                if (r_pix == L_START) r_start <= 1'b1;
            end
            if (w_next == S_FAULT) r_err <= 1'b1;
            if (r_state == S_FIN)             r_go_blk <= go;
            else if (r_state == S_IDLE && !go) r_go_blk <= 1'b0;
            if (w_accept) begin
                r_err   <= 1'b0;
                r_pix   <= '0;
                r_wcnt  <= '0;
                r_wdog  <= '0;
                r_start <= 1'b0;
            end
        end
    end

    assign busy       = (r_state == S_CLR) || w_active;
    assign done       = (r_state == S_FIN);
    assign err        = r_err;
    assign rd_en      = (r_state == S_FEED);
    assign rd_addr    = (r_state == S_FEED) ? r_pix : '0;
    assign eng_clr    = (r_state == S_CLR);
    assign eng_map_in = r_rd_vld ? rd_data : 16'h0000;
    assign eng_start  = r_start && w_active;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: BRAM + engine models, write scoreboard, stream and watchdog models.
module tb_conv_layer_seq;

    localparam int IN_PIX    = 9216;
    localparam int OUT_PIX   = 7744;
    localparam int START_OFS = 863;
    localparam int TIMEOUT   = 1023;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        go     = 1'b0;
    logic        busy, done, err, rd_en, eng_clr, eng_start, wr_en;
    logic [13:0] rd_addr;
    logic [15:0] rd_data = 16'h0;
    logic [15:0] eng_map_in;
    logic        eng_save = 1'b0;
    logic [15:0] eng_map_out = 16'h0;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  dbg_state;

    conv_layer_seq dut (
        .clk_in(clk_in), .rst_n(rst_n), .go(go), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .eng_clr(eng_clr),
        .eng_map_in(eng_map_in), .eng_start(eng_start), .eng_save(eng_save),
        .eng_map_out(eng_map_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_state(dbg_state)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [IN_PIX];
    logic [28:0] exp_q [$];
    logic [15:0] got_q [$];

    int eng_limit, eng_mode, data_mode, n_saves, acc, ec;
    int wr_seen, wr_bad, done_cnt, clr_cnt, stream_bad, k, run, err_run;
    bit start_seen, err_seen;
    logic [15:0] start_val;
    int start_k;

    function automatic logic [15:0] model_wr(input logic [15:0] d);
`ifdef CONV_SEQ_RELU_EN
        return ($signed(d) < 0) ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    always @(posedge clk_in) if (rd_en) rd_data <= mem[rd_addr];

    // Monitors sample the current cycle, then the engine model drives the next inputs.
    always @(negedge clk_in) begin
        logic [28:0] e;
        logic [15:0] d;
        logic [15:0] exp_px;
        if (wr_en) begin
            wr_seen++;
            got_q.push_back(wr_data);
            if (exp_q.size() == 0) wr_bad++;
            else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) wr_bad++;
            end
        end
        if (done) done_cnt++;
        if (eng_clr) begin
            clr_cnt++;
            k = 0;
        end else if (busy) begin
            k++;
            exp_px = (k >= 2 && k <= IN_PIX + 1) ? mem[k-2] : 16'h0;
            if (eng_map_in !== exp_px) stream_bad++;
        end
        if (eng_start && !start_seen) begin
            start_seen = 1;
            start_val  = eng_map_in;
            start_k    = k;
        end
        if (err && !err_seen) begin
            err_seen = 1;
            err_run  = run;
        end
        if (eng_start && n_saves < eng_limit && (eng_mode == 1 || (ec % 96) < 88)) begin
            d = (data_mode == 0) ? 16'($urandom) : (n_saves % 2 == 0 ? 16'hFF00 : 16'h0123);
            eng_save    = 1'b1;
            eng_map_out = d;
            n_saves++;
            if (acc < OUT_PIX) begin
                exp_q.push_back({13'(acc), model_wr(d)});
                acc++;
            end
        end else begin
            eng_save    = 1'b0;
            eng_map_out = 16'($urandom);
        end
        if (eng_start) begin
            ec++;
            run = eng_save ? 0 : run + 1;
        end else ec = 0;
    end

    task automatic clear_job(input int limit, input int mode, input int dmode);
        @(posedge clk_in);
        eng_limit = limit; eng_mode = mode; data_mode = dmode;
        n_saves = 0; acc = 0; ec = 0; run = 0; err_run = 0;
        wr_seen = 0; wr_bad = 0; done_cnt = 0; clr_cnt = 0; stream_bad = 0; k = 0;
        start_seen = 0; err_seen = 0; start_val = 16'h0; start_k = 0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic pulse_go();
        @(negedge clk_in); go = 1'b1;
        @(negedge clk_in); go = 1'b0;
    endtask

    task automatic wait_end(input int bound, output bit to);
        to = 1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_in);
            if (done === 1'b1 || err === 1'b1) begin
                to = 0;
                break;
            end
        end
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        total++;
        if ({busy, done, err, rd_en, rd_addr, eng_clr, eng_map_in, eng_start, wr_en, wr_addr, wr_data, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b done=%b err=%b rd_en=%b wr_en=%b state=%0d exp all 0", busy, done, err, rd_en, wr_en, dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_nominal();
        bit to;
        for (int a = 0; a < IN_PIX; a++) mem[a] = 16'($urandom);
        clear_job(1 << 30, 0, 0);
        pulse_go();
        wait_end(12000, to);
        total++; if (to) begin bad++; $display("FAIL nominal_end timed_out=%0d exp 0", to); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL nominal_done got=%0d exp=1", done_cnt); end
        total++; if (wr_seen != OUT_PIX) begin bad++; $display("FAIL nominal_writes got=%0d exp=%0d", wr_seen, OUT_PIX); end
        total++; if (wr_bad != 0 || exp_q.size() != 0) begin bad++; $display("FAIL nominal_wr_data bad=%0d left=%0d exp 0/0", wr_bad, exp_q.size()); end
        total++; if (stream_bad != 0) begin bad++; $display("FAIL nominal_stream bad=%0d exp=0", stream_bad); end
        total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL nominal_idle busy=%b err=%b exp 0/0", busy, err); end
    endtask

    task automatic test_start_timing();
        bit to;
        for (int a = 0; a < IN_PIX; a++) mem[a] = 16'(a);
        clear_job(1 << 30, 0, 0);
        @(negedge clk_in); go = 1'b1;
        @(negedge clk_in); go = 1'b0;
        total++;
        if (eng_clr !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL clr_after_go eng_clr=%b busy=%b exp 1/1", eng_clr, busy);
        end
        @(negedge clk_in);
        total++; if (eng_clr !== 1'b0) begin bad++; $display("FAIL clr_width eng_clr=%b exp=0", eng_clr); end
        wait_end(12000, to);
        total++; if (to) begin bad++; $display("FAIL start_end timed_out=%0d exp 0", to); end
        total++; if (start_val !== 16'(START_OFS)) begin bad++; $display("FAIL start_pixel got=%0d exp=%0d", start_val, START_OFS); end
        total++; if (start_k != START_OFS + 2) begin bad++; $display("FAIL start_cycle got=%0d exp=%0d", start_k, START_OFS + 2); end
        total++; if (clr_cnt != 1 || done_cnt != 1) begin bad++; $display("FAIL start_pulses clr=%0d done=%0d exp 1/1", clr_cnt, done_cnt); end
    endtask

    task automatic test_timeout();
        bit to;
        clear_job(100, 0, 0);
        pulse_go();
        wait_end(6000, to);
        total++; if (to || err !== 1'b1) begin bad++; $display("FAIL timeout_err err=%b timed_out=%0d exp 1/0", err, to); end
        total++; if (err_run != TIMEOUT) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", err_run, TIMEOUT); end
        total++; if (done_cnt != 0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_nodone done=%0d busy=%b exp 0/0", done_cnt, busy); end
        total++; if (wr_seen != 100 || wr_bad != 0) begin bad++; $display("FAIL timeout_writes got=%0d bad=%0d exp 100/0", wr_seen, wr_bad); end
        clear_job(0, 0, 0);
        pulse_go();
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL go_clears_err err=%b busy=%b exp 0/1", err, busy); end
        wait_end(6000, to);
        total++; if (to || err !== 1'b1 || wr_seen != 0) begin bad++; $display("FAIL timeout_nosave err=%b writes=%0d exp 1/0", err, wr_seen); end
    endtask

    task automatic test_reset_mid_feed();
        bit found = 0;
        int snap;
        clear_job(1 << 30, 0, 0);
        pulse_go();
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk_in);
            if (rd_en === 1'b1 && rd_addr === 14'd5000) begin found = 1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL reach_pixel_5000 found=%0d exp 1", found); end
        rst_n = 1'b0;
        @(negedge clk_in);
        total++;
        if ({busy, done, err, rd_en, rd_addr, eng_clr, eng_map_in, eng_start, wr_en, wr_addr, wr_data, dbg_state} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs busy=%b rd_en=%b eng_start=%b wr_en=%b state=%0d exp all 0", busy, rd_en, eng_start, wr_en, dbg_state);
        end
        rst_n = 1'b1;
        exp_q.delete();
        snap = wr_seen;
        repeat (300) @(negedge clk_in);
        total++; if (wr_seen != snap || busy !== 1'b0 || done_cnt != 0) begin bad++; $display("FAIL midreset_quiet writes=%0d busy=%b done=%0d exp %0d/0/0", wr_seen, busy, done_cnt, snap); end
    endtask

    task automatic test_back_to_back_go();
        bit to;
        int busy_hi = 0;
        for (int a = 0; a < IN_PIX; a++) mem[a] = 16'($urandom);
        clear_job(OUT_PIX + 1, 1, 0);
        @(negedge clk_in); go = 1'b1;
        wait_end(12000, to);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (busy === 1'b1) busy_hi++;
        end
        go = 1'b0;
        @(negedge clk_in);
        total++; if (to || done_cnt != 1 || clr_cnt != 1) begin bad++; $display("FAIL held_go_jobs done=%0d clr=%0d exp 1/1", done_cnt, clr_cnt); end
        total++; if (busy_hi != 0) begin bad++; $display("FAIL held_go_restart busy_cycles=%0d exp=0", busy_hi); end
        total++; if (wr_seen != OUT_PIX || wr_bad != 0) begin bad++; $display("FAIL extra_save_written writes=%0d bad=%0d exp %0d/0", wr_seen, wr_bad, OUT_PIX); end
    endtask

    task automatic test_relu();
        bit to;
        logic [15:0] g0, g1, e0;
`ifdef CONV_SEQ_RELU_EN
        e0 = 16'h0000;
`else
        e0 = 16'hFF00;
`endif
        clear_job(4, 0, 1);
        pulse_go();
        wait_end(6000, to);
        g0 = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
        g1 = (got_q.size() > 1) ? got_q[1] : 16'hxxxx;
        total++; if (g0 !== e0) begin bad++; $display("FAIL relu_negative got=%h exp=%h", g0, e0); end
        total++; if (g1 !== 16'h0123) begin bad++; $display("FAIL relu_positive got=%h exp=0123", g1); end
        total++; if (wr_seen != 4 || wr_bad != 0) begin bad++; $display("FAIL relu_writes got=%0d bad=%0d exp 4/0", wr_seen, wr_bad); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_nominal();
        test_start_timing();
        test_timeout();
        test_reset_mid_feed();
        test_back_to_back_go();
        test_relu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
